// File: rtl/mem_wb_stage.sv
// Memory-access / write-back stage: issues word loads/stores over a req/ack port,
// stalls upstream while an access is outstanding, and registers the write-back bundle.
module mem_wb_stage #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        valid_i,
   input  logic        RegWrite_i,
   input  logic        MemRead_i,
   input  logic        MemWrite_i,
   input  logic        MemtoReg_i,
   input  logic        Branch_i,
   input  logic        Zero_i,
   input  logic [31:0] ALUResult_i,
   input  logic [31:0] rdata2_i,
   input  logic [31:0] addr_jump_i,
   input  logic [4:0]  rd_i,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic        stall_o,
   output logic        pcsrc_o,
   output logic [31:0] pc_target_o,
   output logic        valid_o,
   output logic        RegWrite_o,
   output logic [4:0]  rd_o,
   output logic [31:0] wb_data_o,
   output logic        misalign_o,
   output logic        bus_err_o
);

   typedef enum logic {IDLE, WAIT_ACK} state_t;

   localparam logic [9:0] LP_TMO_LAST = 10'(TIMEOUT_CYCLES - 1);

   state_t      r_state, w_state_nxt;
   logic [9:0]  r_cnt;
   logic [4:0]  r_rd;
   logic        r_regwrite;
   logic        r_memtoreg;

   logic        w_mem, w_misal, w_issue, w_tmo, w_taken;

   assign w_mem   = MemRead_i | MemWrite_i;
   assign w_misal = w_mem & (ALUResult_i[1:0] != 2'b00);
   assign w_issue = (r_state == IDLE) & valid_i & w_mem & ~w_misal;
   assign w_taken = Branch_i & Zero_i;
   // An ack arriving on the timeout edge takes priority, so the timeout term excludes it.
   assign w_tmo   = (r_state == WAIT_ACK) & ~dmem_ack & (r_cnt == LP_TMO_LAST);
   assign stall_o = (r_state == WAIT_ACK);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:     if (w_issue) w_state_nxt = WAIT_ACK;
         WAIT_ACK: if (dmem_ack || w_tmo) w_state_nxt = IDLE;
         default:  w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_rd        <= '0;
         r_regwrite  <= 1'b0;
         r_memtoreg  <= 1'b0;
         dmem_req    <= 1'b0;
         dmem_we     <= 1'b0;
         dmem_addr   <= '0;
         dmem_wdata  <= '0;
         pcsrc_o     <= 1'b0;
         pc_target_o <= '0;
         valid_o     <= 1'b0;
         RegWrite_o  <= 1'b0;
         rd_o        <= '0;
         wb_data_o   <= '0;
         misalign_o  <= 1'b0;
         bus_err_o   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         valid_o    <= 1'b0;
         pcsrc_o    <= 1'b0;
         misalign_o <= 1'b0;
         bus_err_o  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (valid_i) begin
                  pcsrc_o <= w_taken;
                  if (w_taken) pc_target_o <= addr_jump_i;
                  if (!w_mem) begin
                     valid_o    <= 1'b1;
                     rd_o       <= rd_i;
                     wb_data_o  <= ALUResult_i;
                     RegWrite_o <= RegWrite_i & (rd_i != 5'd0);
                  end else if (w_misal) begin
                     misalign_o <= 1'b1;
                     valid_o    <= 1'b1;
                     RegWrite_o <= 1'b0;
                  end else begin
                     dmem_req   <= 1'b1;
                     dmem_we    <= MemWrite_i;
                     dmem_addr  <= ALUResult_i;
                     dmem_wdata <= rdata2_i;
                     r_rd       <= rd_i;
                     r_regwrite <= RegWrite_i;
                     r_memtoreg <= MemtoReg_i;
                     r_cnt      <= '0;
                  end
               end
            end
            WAIT_ACK: begin
               if (dmem_ack) begin
                  dmem_req   <= 1'b0;
                  valid_o    <= 1'b1;
                  rd_o       <= r_rd;
                  wb_data_o  <= r_memtoreg ? dmem_rdata : dmem_addr;
                  RegWrite_o <= r_regwrite & (r_rd != 5'd0);
               end else if (w_tmo) begin
                  dmem_req   <= 1'b0;
                  bus_err_o  <= 1'b1;
                  valid_o    <= 1'b1;
                  RegWrite_o <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 10'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed plan items followed by random instructions,
// each checked against a transaction-level prediction of the stage's outcome.
module tb_mem_wb_stage;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid_i, RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i, Branch_i, Zero_i;
   logic [31:0] ALUResult_i, rdata2_i, addr_jump_i;
   logic [4:0]  rd_i;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic        dmem_req, dmem_we, stall_o, pcsrc_o, valid_o, RegWrite_o, misalign_o, bus_err_o;
   logic [31:0] dmem_addr, dmem_wdata, pc_target_o, wb_data_o;
   logic [4:0]  rd_o;

   int vecs = 0;
   int errs = 0;

   // Model state: values the stage holds between updates
   logic [31:0] m_tgt, m_wb;
   logic [4:0]  m_rd;
   logic        m_rw;

   mem_wb_stage #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .valid_i(valid_i),
      .RegWrite_i(RegWrite_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
      .MemtoReg_i(MemtoReg_i), .Branch_i(Branch_i), .Zero_i(Zero_i),
      .ALUResult_i(ALUResult_i), .rdata2_i(rdata2_i), .addr_jump_i(addr_jump_i),
      .rd_i(rd_i), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .stall_o(stall_o), .pcsrc_o(pcsrc_o),
      .pc_target_o(pc_target_o), .valid_o(valid_o), .RegWrite_o(RegWrite_o),
      .rd_o(rd_o), .wb_data_o(wb_data_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_held();
      chk("pc_target", pc_target_o, m_tgt);
      chk("rd_o", 32'(rd_o), 32'(m_rd));
      chk("wb_data", wb_data_o, m_wb);
      chk("RegWrite", 32'(RegWrite_o), 32'(m_rw));
   endtask

   task automatic idle_cycle();
      valid_i = 1'b0;
      step();
      chk("idle.valid", 32'(valid_o), 0);
      chk("idle.pcsrc", 32'(pcsrc_o), 0);
      chk("idle.misalign", 32'(misalign_o), 0);
      chk("idle.bus_err", 32'(bus_err_o), 0);
      chk("idle.stall", 32'(stall_o), 0);
      chk_held();
   endtask

   // Presents one instruction, responds with dmem_ack after 'lat' request cycles,
   // and checks the outcome predicted from the instruction fields.
   task automatic do_instr(input logic rw, input logic mr, input logic mw, input logic m2r,
                           input logic br, input logic z, input logic [31:0] alu,
                           input logic [31:0] d2, input logic [31:0] jmp, input logic [4:0] rd,
                           input int lat, input logic [31:0] rdata);
      int ret;
      valid_i = 1'b1; RegWrite_i = rw; MemRead_i = mr; MemWrite_i = mw; MemtoReg_i = m2r;
      Branch_i = br; Zero_i = z; ALUResult_i = alu; rdata2_i = d2; addr_jump_i = jmp;
      rd_i = rd; dmem_ack = 1'b0; dmem_rdata = rdata;
      step();
      valid_i = 1'b0;
      chk("pcsrc", 32'(pcsrc_o), 32'(br & z));
      if (br && z) m_tgt = jmp;
      if (!(mr || mw)) begin
         m_rd = rd; m_wb = alu; m_rw = rw && (rd != 0);
         chk("alu.valid", 32'(valid_o), 1);
         chk("alu.stall", 32'(stall_o), 0);
         chk("alu.req", 32'(dmem_req), 0);
         chk_held();
      end else if (alu % 4 != 0) begin
         m_rw = 1'b0;
         chk("mis.valid", 32'(valid_o), 1);
         chk("mis.flag", 32'(misalign_o), 1);
         chk("mis.req", 32'(dmem_req), 0);
         chk("mis.stall", 32'(stall_o), 0);
         chk_held();
      end else begin
         chk("mem.req", 32'(dmem_req), 1);
         chk("mem.we", 32'(dmem_we), 32'(mw));
         chk("mem.addr", dmem_addr, alu);
         chk("mem.wdata", dmem_wdata, d2);
         chk("mem.stall", 32'(stall_o), 1);
         chk("mem.valid0", 32'(valid_o), 0);
         chk("pc_target", pc_target_o, m_tgt);
         ret = (lat <= TMO) ? lat : TMO;
         for (int k = 1; k <= ret; k++) begin
            // garbage on the upstream bus must be ignored while stalled
            RegWrite_i = 1'($urandom); ALUResult_i = $urandom; rd_i = 5'($urandom);
            dmem_ack = (k == lat);
            step();
            if (k < ret) begin
               chk("wait.req", 32'(dmem_req), 1);
               chk("wait.stall", 32'(stall_o), 1);
               chk("wait.addr", dmem_addr, alu);
               chk("wait.valid", 32'(valid_o), 0);
               chk("wait.pcsrc", 32'(pcsrc_o), 0);
            end
         end
         dmem_ack = 1'b0;
         chk("ret.req", 32'(dmem_req), 0);
         chk("ret.stall", 32'(stall_o), 0);
         chk("ret.valid", 32'(valid_o), 1);
         chk("ret.pcsrc", 32'(pcsrc_o), 0);
         if (lat <= TMO) begin
            m_rd = rd; m_wb = m2r ? rdata : alu; m_rw = rw && (rd != 0);
            chk("ret.bus_err", 32'(bus_err_o), 0);
         end else begin
            m_rw = 1'b0;
            chk("tmo.bus_err", 32'(bus_err_o), 1);
         end
         chk_held();
      end
   endtask

   initial begin
      logic        r_mem, r_mw, r_rw;
      logic [31:0] r_alu;
      rst_n = 1'b0; valid_i = 1'b0; RegWrite_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0;
      MemtoReg_i = 1'b0; Branch_i = 1'b0; Zero_i = 1'b0; ALUResult_i = '0; rdata2_i = '0;
      addr_jump_i = '0; rd_i = '0; dmem_ack = 1'b0; dmem_rdata = '0;
      m_tgt = '0; m_wb = '0; m_rd = '0; m_rw = 1'b0;
      #12;
      chk("rst.req", 32'(dmem_req), 0);
      chk("rst.stall", 32'(stall_o), 0);
      chk("rst.valid", 32'(valid_o), 0);
      chk_held();
      rst_n = 1'b1;
      step();
      chk("rst.idle_stall", 32'(stall_o), 0);

      // ALU ops, rd=0 suppresses RegWrite
      do_instr(1, 0, 0, 0, 0, 0, 32'h1234, 0, 0, 5'd5, 1, 0);
      do_instr(1, 0, 0, 0, 0, 0, 32'h5678, 0, 0, 5'd0, 1, 0);
      idle_cycle();
      // load with 3-cycle ack, back-to-back with next instruction
      do_instr(1, 1, 0, 1, 0, 0, 32'h100, 0, 0, 5'd7, 3, 32'hDEADBEEF);
      do_instr(1, 0, 0, 0, 0, 0, 32'hCAFE, 0, 0, 5'd9, 1, 0);
      // store plus taken branch
      do_instr(0, 0, 1, 0, 1, 1, 32'h20, 32'hA5A5A5A5, 32'h400, 5'd3, 2, 32'h1111);
      idle_cycle();
      // both read and write set: store wins
      do_instr(0, 1, 1, 0, 0, 0, 32'h24, 32'h77, 0, 5'd4, 1, 0);
      // misaligned load
      do_instr(1, 1, 0, 1, 0, 0, 32'h102, 0, 0, 5'd6, 1, 0);
      idle_cycle();
      // timeout, then ack exactly on the timeout edge
      do_instr(1, 1, 0, 1, 0, 0, 32'h200, 0, 0, 5'd8, TMO + 3, 32'h0BAD);
      idle_cycle();
      do_instr(1, 1, 0, 1, 0, 0, 32'h204, 0, 0, 5'd8, TMO, 32'h600D);
      idle_cycle();
      // untaken branch leaves target unchanged
      do_instr(0, 0, 0, 0, 1, 0, 32'h0, 0, 32'h999, 5'd1, 1, 0);

      // asynchronous reset in the middle of an access
      valid_i = 1'b1; RegWrite_i = 1'b1; MemRead_i = 1'b1; MemWrite_i = 1'b0; MemtoReg_i = 1'b1;
      Branch_i = 1'b1; Zero_i = 1'b1; ALUResult_i = 32'h300; addr_jump_i = 32'h880; rd_i = 5'd2;
      step();
      valid_i = 1'b0;
      chk("arst.pre_req", 32'(dmem_req), 1);
      #2 rst_n = 1'b0;
      #1;
      m_tgt = '0; m_wb = '0; m_rd = '0; m_rw = 1'b0;
      chk("arst.req", 32'(dmem_req), 0);
      chk("arst.stall", 32'(stall_o), 0);
      chk("arst.pcsrc", 32'(pcsrc_o), 0);
      chk("arst.addr", dmem_addr, 0);
      chk_held();
      #3 rst_n = 1'b1;
      step();
      chk("arst.no_resume", 32'(dmem_req), 0);
      chk("arst.idle", 32'(stall_o), 0);

      // random instructions
      for (int n = 0; n < 80; n++) begin
         r_mem = ($urandom_range(2) != 0);
         r_mw  = r_mem && ($urandom_range(1) == 1);
         r_rw  = r_mw ? 1'b0 : 1'($urandom);
         r_alu = $urandom;
         if ($urandom_range(3) != 0) r_alu[1:0] = 2'b00;
         do_instr(r_rw, r_mem & ~r_mw, r_mw, r_mem & ~r_mw & 1'($urandom),
                  1'($urandom), 1'($urandom), r_alu, $urandom, $urandom,
                  5'($urandom), int'($urandom_range(6, 1)), $urandom);
         if ($urandom_range(3) == 0) idle_cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access stage directly downstream of the EX/MEM pipeline register.
- Consumes the EX/MEM control and data outputs and performs word loads and stores through a req/ack data-memory port.
- Resolves the registered branch decision, stalls upstream while a memory access is outstanding, and presents the registered write-back bundle to the register file.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in WAIT_ACK before the access is abandoned as a bus error (range 1..1023).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- valid_i  in  1  EX/MEM holds a live instruction
- RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i, Branch_i, Zero_i  in  1 each  EX/MEM control
- ALUResult_i  in  32  ALU result; memory byte address for loads/stores
- rdata2_i  in  32  store data
- addr_jump_i  in  32  branch target
- rd_i  in  5  destination register
- dmem_ack  in  1  memory completes the access (sampled while dmem_req=1)
- dmem_rdata  in  32  load data, valid with dmem_ack
- dmem_req  out  1  access request (registered)
- dmem_we  out  1  1=store, 0=load (registered)
- dmem_addr  out  32  word-aligned address (registered)
- dmem_wdata  out  32  store data (registered)
- stall_o  out  1  upstream must hold EX/MEM contents
- pcsrc_o  out  1  one-cycle taken-branch pulse (registered)
- pc_target_o  out  32  branch target, valid with pcsrc_o
- valid_o  out  1  write-back bundle valid, one-cycle pulse per retired instruction
- RegWrite_o  out  1  register-file write enable
- rd_o  out  5  write-back register
- wb_data_o  out  32  write-back data
- misalign_o  out  1  one-cycle pulse: misaligned access dropped
- bus_err_o  out  1  one-cycle pulse: access timed out

Behaviour:
- Reset is asynchronous and active-low on rst_n.
  - Reset forces state IDLE, wait counter 0, and every output to 0 immediately, including dmem_req mid-access.
  - After reset, an abandoned access is not resumed.
- stall_o = (state == WAIT_ACK), decoded combinationally from state.
- FSM states: IDLE, WAIT_ACK.
- IDLE, rising edge with valid_i=1 (instruction accepted):
  - pcsrc_o <= Branch_i & Zero_i; pc_target_o <= addr_jump_i (held until the next taken branch).
  - Non-memory op (MemRead_i=0, MemWrite_i=0): single-cycle latency.
    - valid_o <= 1; rd_o <= rd_i; wb_data_o <= ALUResult_i.
    - RegWrite_o <= RegWrite_i & (rd_i != 0).
  - Memory op with ALUResult_i[1:0] != 0: no request is issued.
    - misalign_o <= 1; valid_o <= 1; RegWrite_o <= 0.
  - Aligned memory op:
    - dmem_req <= 1; dmem_we <= MemWrite_i (MemWrite wins if both MemRead_i and MemWrite_i are set).
    - dmem_addr <= ALUResult_i; dmem_wdata <= rdata2_i.
    - rd, RegWrite and MemtoReg are captured internally; counter cleared; go to WAIT_ACK.
- IDLE with valid_i=0: valid_o, pcsrc_o, misalign_o and bus_err_o are 0 next cycle.
- WAIT_ACK:
  - dmem_req and the address/data outputs are held stable; the counter increments each cycle; valid_i is ignored.
  - Edge with dmem_ack=1:
    - dmem_req <= 0; valid_o <= 1; rd_o <= captured rd.
    - wb_data_o <= captured MemtoReg ? dmem_rdata : dmem_addr.
    - RegWrite_o <= captured RegWrite & (rd != 0); go to IDLE.
  - Edge where the counter reaches TIMEOUT_CYCLES-1 with dmem_ack=0:
    - dmem_req <= 0; bus_err_o <= 1; valid_o <= 1; RegWrite_o <= 0; go to IDLE.
  - If dmem_ack and the timeout occur on the same edge, dmem_ack wins and there is no bus_err_o.
- The instruction held upstream during the stall is accepted on the first IDLE edge after return. Each memory op therefore costs at least 2 cycles plus memory latency.
- valid_o, pcsrc_o, misalign_o and bus_err_o are single-cycle pulses. All other outputs hold their values between updates.
- Stores never write the register file, because RegWrite_i is 0 for stores.

Test Plan:
- Reset: drop rst_n to 0 mid-cycle while in WAIT_ACK -> dmem_req, stall_o and all outputs go to 0 without waiting for a clock edge. After release, state is IDLE.
- ALU op: valid_i=1, RegWrite_i=1, rd_i=5, ALUResult_i=0x1234 -> next edge valid_o=1, RegWrite_o=1, rd_o=5, wb_data_o=0x1234, stall_o=0. Repeat with rd_i=0 -> RegWrite_o=0.
- Load, ack after 3 cycles: ALUResult_i=0x100, MemRead_i=1, MemtoReg_i=1, rd_i=7, dmem_rdata=0xDEADBEEF ->
  - dmem_req=1, dmem_we=0, dmem_addr=0x100 and stall_o=1 for 3 cycles;
  - then valid_o=1, RegWrite_o=1, rd_o=7, wb_data_o=0xDEADBEEF;
  - the next instruction is accepted one edge later.
- Store plus branch: MemWrite_i=1, rdata2_i=0xA5A5A5A5, ALUResult_i=0x20, Branch_i=1, Zero_i=1, addr_jump_i=0x400 ->
  - dmem_we=1, dmem_wdata=0xA5A5A5A5;
  - pcsrc_o one-cycle pulse with pc_target_o=0x400;
  - RegWrite_o=0 at retire.
- Misaligned: MemRead_i=1, ALUResult_i=0x102 -> no dmem_req; misalign_o and valid_o pulse; RegWrite_o=0.
- Timeout: TIMEOUT_CYCLES=4, dmem_ack held 0 -> dmem_req drops after 4 cycles with a bus_err_o pulse and RegWrite_o=0. Second run: dmem_ack=1 on the timeout edge -> normal retire, bus_err_o=0.
